serial_subtractor: RTL



---
 rtl/sub_pkg.sv | 13 +
 rtl/subtract_digit.sv | 26 ++
 rtl/serial_subtractor.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared constants for the digit-serial subtractor: default geometry and FSM encoding.
package sub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subtract_digit.sv
// Combinational DIGIT-wide ripple chain of full-subtractor cells: d = x - y - bin.
module subtract_digit
  import sub_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign d[i]       = x[i] ^ y[i] ^ brw[i];
    // Borrow out when y beats x, or they tie and a borrow is already pending.
    assign brw[i+1]   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
  end

  assign bout = brw[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial a - b: one DIGIT-wide slice per clock, LSB first, with a registered
// borrow between slices and a start/busy/done handshake.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [DIGIT-1:0] x_dig, y_dig, d_dig;
  logic             bout;
  int               base;

  subtract_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (x_dig),
    .y    (y_dig),
    .bin  (brw_q),
    .d    (d_dig),
    .bout (bout)
  );

  always_comb begin
    base  = int'(cnt_q) * DIGIT;
    x_dig = a_q[base +: DIGIT];
    y_dig = b_q[base +: DIGIT];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    brw_d    = brw_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        diff_d[base +: DIGIT] = d_dig;
        brw_d = bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          borrow_d = bout;
          // The final digit holds the result MSB, so no need to wait for diff_q.
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_dig[DIGIT-1] != a_q[WIDTH-1]);
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_RUN;
          a_d      = a;
          b_d      = b;
          cnt_d    = '0;
          brw_d    = 1'b0;
          diff_d   = '0;
          borrow_d = 1'b0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule
